// File: rtl/biriscv_mul_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : biriscv_mul_tracker_pkg
//  Description : Shared types, multiply-instruction encodings and decode
//                helper for the multiplier tag tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package biriscv_mul_tracker_pkg;

  // RV32M multiply encodings and the mask selecting funct7/funct3/opcode
  localparam logic [31:0] c_inst_mul      = 32'h02000033;
  localparam logic [31:0] c_inst_mulh     = 32'h02001033;
  localparam logic [31:0] c_inst_mulhsu   = 32'h02002033;
  localparam logic [31:0] c_inst_mulhu    = 32'h02003033;
  localparam logic [31:0] c_inst_mul_mask = 32'hfe00707f;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] pc;
  } mul_tag_t;

  function automatic logic is_mul_inst(input logic [31:0] inst);
    logic [31:0] masked;
    masked = inst & c_inst_mul_mask;
    return (masked == c_inst_mul)    || (masked == c_inst_mulh) ||
           (masked == c_inst_mulhsu) || (masked == c_inst_mulhu);
  endfunction

endpackage : biriscv_mul_tracker_pkg
`default_nettype wire

// File: rtl/biriscv_mul_tag_stage.sv
`default_nettype none
// ============================================================================
//  Module      : biriscv_mul_tag_stage
//  Description : One valid/rd/pc tag register of the multiplier shadow pipe.
//                Holds on hold_i; flush_i clears valid even while holding.
//  Revision    : 1.0 - initial release
// ============================================================================
module biriscv_mul_tag_stage
  import biriscv_mul_tracker_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     hold_i,
  input  logic     flush_i,
  input  mul_tag_t tag_i,
  output mul_tag_t tag_o
);

  mul_tag_t r_tag;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag <= '0;
    end else begin
      if (!hold_i)
        r_tag <= tag_i;
      // Flush has priority over hold: the data fields may stay, the op may not
      if (flush_i)
        r_tag.valid <= 1'b0;
    end
  end

  assign tag_o = r_tag;

endmodule : biriscv_mul_tag_stage
`default_nettype wire

// File: rtl/biriscv_mul_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : biriscv_mul_tracker
//  Description : Shadows the pipelined multiplier with per-op tags, emits the
//                aligned writeback request, a pending-rd scoreboard for issue
//                hazards, and sticky/counted capture of the multiplier error.
//  Revision    : 1.0 - initial release
// ============================================================================
module biriscv_mul_tracker
  import biriscv_mul_tracker_pkg::*;
#(
  parameter int MULT_STAGES = 2,
  parameter int ERR_CNT_W   = 8
)(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 opcode_valid_i,
  input  logic [31:0]          opcode_opcode_i,
  input  logic [31:0]          opcode_pc_i,
  input  logic [4:0]           opcode_rd_idx_i,
  input  logic [4:0]           opcode_ra_idx_i,
  input  logic [4:0]           opcode_rb_idx_i,
  input  logic                 hold_i,
  input  logic                 flush_i,
  input  logic [31:0]          mul_result_i,
  input  logic                 mul_error_i,
  input  logic                 err_clr_i,
  output logic                 wb_valid_o,
  output logic [4:0]           wb_rd_idx_o,
  output logic [31:0]          wb_value_o,
  output logic [31:0]          wb_pc_o,
  output logic [31:0]          pending_o,
  output logic                 hazard_o,
  output logic                 err_sticky_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam logic [ERR_CNT_W-1:0] c_err_cnt_max = '1;
  localparam logic [ERR_CNT_W-1:0] c_err_cnt_one = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Tag pipeline: s1 lives here because it owns the decode qualification.
  // --------------------------------------------------------------------------
  mul_tag_t                   w_s1_next;
  mul_tag_t                   r_s1;
  mul_tag_t [MULT_STAGES-1:0] w_stage;

  always_comb begin
    w_s1_next       = '0;
    w_s1_next.valid = opcode_valid_i & is_mul_inst(opcode_opcode_i) &
                      (opcode_rd_idx_i != 5'd0) & ~flush_i;
    w_s1_next.rd    = opcode_rd_idx_i;
    w_s1_next.pc    = opcode_pc_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1 <= '0;
    end else begin
      if (!hold_i)
        r_s1 <= w_s1_next;
      if (flush_i)
        r_s1.valid <= 1'b0;
    end
  end

  assign w_stage[0] = r_s1;

  generate
    for (genvar g = 1; g < MULT_STAGES; g++) begin : g_stage
      biriscv_mul_tag_stage u_stage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .hold_i  (hold_i),
        .flush_i (flush_i),
        .tag_i   (w_stage[g-1]),
        .tag_o   (w_stage[g])
      );
    end
  endgenerate

  assign wb_valid_o  = w_stage[MULT_STAGES-1].valid;
  assign wb_rd_idx_o = w_stage[MULT_STAGES-1].rd;
  assign wb_pc_o     = w_stage[MULT_STAGES-1].pc;
  assign wb_value_o  = mul_result_i;

  // --------------------------------------------------------------------------
  // Pending scoreboard and issue hazard (no forwarding assumed)
  // --------------------------------------------------------------------------
  logic [31:0] w_pending;

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < MULT_STAGES; i++) begin
      if (w_stage[i].valid)
        w_pending[w_stage[i].rd] = 1'b1;
    end
    w_pending[0] = 1'b0;
  end

  assign pending_o = w_pending;
  assign hazard_o  = opcode_valid_i &
                     (((opcode_ra_idx_i != 5'd0) & w_pending[opcode_ra_idx_i]) |
                      ((opcode_rb_idx_i != 5'd0) & w_pending[opcode_rb_idx_i]));

  // --------------------------------------------------------------------------
  // Error capture: independent of hold/flush; set/rise beats clear.
  // --------------------------------------------------------------------------
  logic                 r_err_q;
  logic                 r_err_sticky;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic                 w_err_rise;

  assign w_err_rise = mul_error_i & ~r_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_q      <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_err_q <= mul_error_i;

      if (mul_error_i)
        r_err_sticky <= 1'b1;
      else if (err_clr_i)
        r_err_sticky <= 1'b0;

      if (w_err_rise) begin
        if (err_clr_i)
          r_err_count <= c_err_cnt_one;
        else if (r_err_count != c_err_cnt_max)
          r_err_count <= r_err_count + c_err_cnt_one;
      end else if (err_clr_i) begin
        r_err_count <= '0;
      end
    end
  end

  assign err_sticky_o = r_err_sticky;
  assign err_count_o  = r_err_count;

endmodule : biriscv_mul_tracker
`default_nettype wire

// File: tb/tb_biriscv_mul_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_biriscv_mul_tracker
//  Description : Self-checking bench for biriscv_mul_tracker against an
//                in-flight-op list model with per-op age counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_biriscv_mul_tracker;

  localparam int MS   = 2;
  localparam int ECW  = 8;
  localparam int EMAX = (1 << ECW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            ov;
  logic [31:0]     opc, pc, mres;
  logic [4:0]      rd, ra, rb;
  logic            hold, flush, merr, clr;
  logic            wb_valid, hazard, err_sticky;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_value, wb_pc, pending;
  logic [ECW-1:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  biriscv_mul_tracker #(.MULT_STAGES(MS), .ERR_CNT_W(ECW)) dut (
    .clk_i(clk), .rst_i(rst),
    .opcode_valid_i(ov), .opcode_opcode_i(opc), .opcode_pc_i(pc),
    .opcode_rd_idx_i(rd), .opcode_ra_idx_i(ra), .opcode_rb_idx_i(rb),
    .hold_i(hold), .flush_i(flush), .mul_result_i(mres),
    .mul_error_i(merr), .err_clr_i(clr),
    .wb_valid_o(wb_valid), .wb_rd_idx_o(wb_rd), .wb_value_o(wb_value),
    .wb_pc_o(wb_pc), .pending_o(pending), .hazard_o(hazard),
    .err_sticky_o(err_sticky), .err_count_o(err_count)
  );

  // Reference model: list of ops in flight, each aging one step per
  // non-held edge; an op writes back when its age equals the latency.
  typedef struct { logic [4:0] rd; logic [31:0] pc; int age; } op_t;
  op_t inflight[$];
  int  m_count;
  bit  m_sticky, m_err_prev;

  function automatic logic [31:0] mk(input int f3, input int f7, input logic [4:0] rdv);
    logic [6:0] f7v; logic [2:0] f3v;
    f7v = f7[6:0]; f3v = f3[2:0];
    return {f7v, 5'd1, 5'd2, f3v, rdv, 7'h33};
  endfunction

  function automatic bit m_is_mul(input logic [31:0] w);
    return (w[6:0] == 7'h33) && (w[31:25] == 7'h01) && (w[14:12] < 3'd4);
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    foreach (inflight[i]) p[inflight[i].rd] = 1'b1;
    return p;
  endfunction

  task automatic m_wb(output bit v, output logic [4:0] r, output logic [31:0] p);
    v = 0; r = '0; p = '0;
    foreach (inflight[i]) if (inflight[i].age == MS) begin v = 1; r = inflight[i].rd; p = inflight[i].pc; end
  endtask

  function automatic bit m_hazard();
    logic [31:0] p;
    p = m_pending();
    return ov && ((ra != 0 && p[ra]) || (rb != 0 && p[rb]));
  endfunction

  task automatic model_reset();
    inflight.delete();
    m_count = 0; m_sticky = 0; m_err_prev = 0;
  endtask

  // Advance the model with the current inputs, then cross the clock edge.
  task automatic tick();
    bit rise;
    rise = merr && !m_err_prev;
    if (clr) m_count = rise ? 1 : 0;
    else if (rise && m_count < EMAX) m_count++;
    m_sticky   = merr || (m_sticky && !clr);
    m_err_prev = merr;
    if (flush) inflight.delete();
    else if (!hold) begin
      for (int i = 0; i < inflight.size(); i++) inflight[i].age++;
      while (inflight.size() > 0 && inflight[0].age > MS) void'(inflight.pop_front());
      if (ov && m_is_mul(opc) && rd != 0) inflight.push_back('{rd, pc, 1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ov = 0; opc = '0; pc = '0; rd = '0; ra = '0; rb = '0;
    hold = 0; flush = 0; merr = 0; clr = 0; mres = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); ov = 1; ra = 5'd5; model_reset();
    #2;
    n_tests++; if ({wb_valid, wb_rd, wb_pc, pending, hazard} !== '0) begin n_fail++;
      $display("FAIL reset_async: wb_valid=%0b rd=%0d pc=%h pending=%h hazard=%0b, want all 0", wb_valid, wb_rd, wb_pc, pending, hazard); end
    n_tests++; if ({err_sticky, err_count} !== '0) begin n_fail++;
      $display("FAIL reset_err: sticky=%0b count=%0d, want 0/0", err_sticky, err_count); end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if ({wb_valid, pending} !== '0) begin n_fail++;
      $display("FAIL reset_held: wb_valid=%0b pending=%h, want 0", wb_valid, pending); end
    @(negedge clk); rst = 0; ov = 0; ra = 0;
  endtask

  task automatic test_basic();
    ov = 1; opc = mk(0, 1, 5'd5); rd = 5'd5; pc = 32'h100; ra = 5'd1; rb = 5'd2;
    mres = 32'hCAFE_0005;
    tick();
    ov = 0;
    n_tests++; if (wb_valid !== 1'b0 || pending !== 32'h20) begin n_fail++;
      $display("FAIL basic_inflight: wb_valid=%0b pending=%h, want 0 / 00000020", wb_valid, pending); end
    tick();
    n_tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_pc !== 32'h100) begin n_fail++;
      $display("FAIL basic_wb: valid=%0b rd=%0d pc=%h, want 1 5 00000100", wb_valid, wb_rd, wb_pc); end
    n_tests++; if (wb_value !== 32'hCAFE_0005 || pending !== 32'h20) begin n_fail++;
      $display("FAIL basic_wb_value: value=%h pending=%h, want cafe0005 00000020", wb_value, pending); end
    tick();
    n_tests++; if (wb_valid !== 1'b0 || pending !== 32'h0) begin n_fail++;
      $display("FAIL basic_retired: wb_valid=%0b pending=%h, want 0 0", wb_valid, pending); end
  endtask

  task automatic test_hold();
    ov = 1; opc = mk(3, 1, 5'd7); rd = 5'd7; pc = 32'h200;
    tick();
    ov = 0;
    tick();
    hold = 1; ov = 1; rd = 5'd8; opc = mk(0, 1, 5'd8); pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_pc !== 32'h200 || pending !== 32'h80) begin n_fail++;
        $display("FAIL hold_frozen[%0d]: valid=%0b rd=%0d pc=%h pending=%h, want 1 7 00000200 00000080", i, wb_valid, wb_rd, wb_pc, pending); end
    end
    hold = 0; ov = 0;
    tick();
    n_tests++; if (wb_valid !== 1'b0 || pending !== 32'h0) begin n_fail++;
      $display("FAIL hold_release: wb_valid=%0b pending=%h, want 0 0", wb_valid, pending); end
  endtask

  task automatic test_flush();
    ov = 1; opc = mk(0, 1, 5'd3); rd = 5'd3; pc = 32'h400;
    tick();
    opc = mk(3, 1, 5'd4); rd = 5'd4; pc = 32'h404; flush = 1;
    tick();
    n_tests++; if (wb_valid !== 1'b0 || pending !== 32'h0) begin n_fail++;
      $display("FAIL flush_edge: wb_valid=%0b pending=%h, want 0 0", wb_valid, pending); end
    flush = 0; ov = 0;
    tick();
    n_tests++; if (wb_valid !== 1'b0 || pending !== 32'h0) begin n_fail++;
      $display("FAIL flush_after: wb_valid=%0b pending=%h, want 0 0", wb_valid, pending); end
    ov = 1; opc = mk(1, 1, 5'd6); rd = 5'd6;
    tick();
    ov = 0; hold = 1; flush = 1;
    tick();
    n_tests++; if (pending !== 32'h0 || wb_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_over_hold: wb_valid=%0b pending=%h, want 0 0", wb_valid, pending); end
    hold = 0; flush = 0;
    tick();
  endtask

  task automatic test_rd_zero_hazard();
    ov = 1; opc = mk(1, 1, 5'd0); rd = 5'd0; pc = 32'h500;
    tick();
    ov = 0;
    n_tests++; if (wb_valid !== 1'b0 || pending !== 32'h0) begin n_fail++;
      $display("FAIL rd0_s1: wb_valid=%0b pending=%h, want 0 0", wb_valid, pending); end
    tick();
    n_tests++; if (wb_valid !== 1'b0 || pending !== 32'h0) begin n_fail++;
      $display("FAIL rd0_wb: wb_valid=%0b pending=%h, want 0 0", wb_valid, pending); end
    ov = 1; opc = mk(0, 1, 5'd9); rd = 5'd9; pc = 32'h504;
    tick();
    opc = mk(0, 0, 5'd1); rd = 5'd1; ra = 5'd0; rb = 5'd0;
    #1;
    n_tests++; if (hazard !== 1'b0) begin n_fail++;
      $display("FAIL hazard_ra0: got %0b want 0", hazard); end
    ra = 5'd9; #1;
    n_tests++; if (hazard !== 1'b1) begin n_fail++;
      $display("FAIL hazard_ra9: got %0b want 1", hazard); end
    ra = 5'd0; rb = 5'd9; #1;
    n_tests++; if (hazard !== 1'b1) begin n_fail++;
      $display("FAIL hazard_rb9: got %0b want 1", hazard); end
    ov = 0; #1;
    n_tests++; if (hazard !== 1'b0) begin n_fail++;
      $display("FAIL hazard_novalid: got %0b want 0", hazard); end
    rb = 5'd0;
    tick(); tick();
  endtask

  task automatic test_error();
    merr = 1; tick(); merr = 0; tick();
    n_tests++; if (err_count !== 8'd1 || err_sticky !== 1'b1) begin n_fail++;
      $display("FAIL err_first: count=%0d sticky=%0b, want 1 1", err_count, err_sticky); end
    for (int i = 1; i < 300; i++) begin merr = 1; tick(); merr = 0; tick(); end
    n_tests++; if (err_count !== 8'd255 || err_sticky !== 1'b1) begin n_fail++;
      $display("FAIL err_saturate: count=%0d sticky=%0b, want 255 1", err_count, err_sticky); end
    clr = 1; tick();
    n_tests++; if (err_count !== 8'd0 || err_sticky !== 1'b0) begin n_fail++;
      $display("FAIL err_clear: count=%0d sticky=%0b, want 0 0", err_count, err_sticky); end
    merr = 1; tick();
    n_tests++; if (err_count !== 8'd1 || err_sticky !== 1'b1) begin n_fail++;
      $display("FAIL err_clr_vs_rise: count=%0d sticky=%0b, want 1 1", err_count, err_sticky); end
    tick();
    n_tests++; if (err_count !== 8'd0 || err_sticky !== 1'b1) begin n_fail++;
      $display("FAIL err_clr_level: count=%0d sticky=%0b, want 0 1", err_count, err_sticky); end
    merr = 0; tick();
    clr = 0;
  endtask

  task automatic test_mid_reset();
    ov = 1; opc = mk(2, 1, 5'd11); rd = 5'd11; pc = 32'h600;
    tick();
    ov = 0; merr = 1;
    tick();
    #2 rst = 1; #1;
    model_reset();
    n_tests++; if (wb_valid !== 1'b0 || pending !== 32'h0 || err_count !== 8'd0) begin n_fail++;
      $display("FAIL mid_reset: wb_valid=%0b pending=%h count=%0d, want 0 0 0", wb_valid, pending, err_count); end
    merr = 0;
    @(negedge clk); rst = 0;
    tick();
    n_tests++; if (wb_valid !== 1'b0 || pending !== 32'h0) begin n_fail++;
      $display("FAIL mid_reset_after: wb_valid=%0b pending=%h, want 0 0", wb_valid, pending); end
  endtask

  task automatic test_random();
    bit          ev;
    logic [4:0]  er;
    logic [31:0] ep, epend;
    for (int c = 0; c < 800; c++) begin
      ov    = ($urandom_range(3) != 0);
      rd    = 5'($urandom_range(7));
      case ($urandom_range(3))
        0, 1: opc = mk($urandom_range(7), 1, rd);
        2:    opc = mk($urandom_range(7), 0, rd);
        default: opc = $urandom;
      endcase
      pc    = $urandom & 32'hFFFF_FFFC;
      ra    = 5'($urandom_range(7));
      rb    = 5'($urandom_range(7));
      hold  = ($urandom_range(4) == 0);
      flush = ($urandom_range(9) == 0);
      merr  = ($urandom_range(2) == 0);
      clr   = ($urandom_range(15) == 0);
      mres  = $urandom;
      #1;
      m_wb(ev, er, ep);
      epend = m_pending();
      n_tests++; if (wb_valid !== ev || (ev && (wb_rd !== er || wb_pc !== ep))) begin n_fail++;
        $display("FAIL rnd_wb[%0d]: valid=%0b rd=%0d pc=%h, want %0b %0d %h", c, wb_valid, wb_rd, wb_pc, ev, er, ep); end
      n_tests++; if (pending !== epend || hazard !== m_hazard() || wb_value !== mres) begin n_fail++;
        $display("FAIL rnd_pend[%0d]: pending=%h hazard=%0b value=%h, want %h %0b %h", c, pending, hazard, wb_value, epend, m_hazard(), mres); end
      n_tests++; if (err_sticky !== m_sticky || int'(err_count) != m_count) begin n_fail++;
        $display("FAIL rnd_err[%0d]: sticky=%0b count=%0d, want %0b %0d", c, err_sticky, err_count, m_sticky, m_count); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_flush();
    test_rd_zero_hazard();
    test_error();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_biriscv_mul_tracker
`default_nettype wire
